mac_accumulator: RTL

- Downstream consumer of the 32x32 signed synchronous multiplier.
- Accumulates a programmed number of signed 64-bit products into a saturating signed accumulator. Presents the final sum through a valid/ready result handshake.
- Runs entirely in the slow_clk domain, so each product is sampled once per multiplier result period.

---
 rtl/mac_accumulator_if.sv | 27 ++
 rtl/mac_accumulator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the multiplier side, the accumulator and the result consumer.
// The accumulator drives through the slave modport; the stimulus or upstream logic uses master.
interface mac_accumulator_if #(
    parameter int WIDTH = 64,
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] prod;
    logic             prod_valid;
    logic             prod_ready;
    logic [WIDTH-1:0] res;
    logic             res_valid;
    logic             res_ready;
    logic             ovf;
    logic             busy;

    modport master (
        output start, len, prod, prod_valid, res_ready,
        input  prod_ready, res, res_valid, ovf, busy
    );

    modport slave (
        input  start, len, prod, prod_valid, res_ready,
        output prod_ready, res, res_valid, ovf, busy
    );
endinterface

// File: rtl/mac_accumulator.sv
// Sums a programmed number of signed products with optional saturation and
// returns the total over a valid/ready result handshake.
module mac_accumulator #(
    parameter int WIDTH    = 64,
    parameter int LEN_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic             slow_clk,
    input  logic             rst,
    mac_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MAX_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Signed overflow: operands agree in sign but the sum does not.
    function automatic logic add_ovf(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    state_e           state_r;
    state_e           state_nxt_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [LEN_W-1:0] count_r;
    logic [LEN_W-1:0] count_nxt_s;
    logic [LEN_W-1:0] len_q_r;
    logic [LEN_W-1:0] len_q_nxt_s;
    logic             ovf_r;
    logic             ovf_nxt_s;
    logic [WIDTH-1:0] res_r;
    logic             res_valid_r;
    logic             prod_ready_r;
    logic             busy_r;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_det_s;
    logic             accept_s;
    logic             last_s;

    assign sum_s     = acc_r + bus.prod;
    assign ovf_det_s = add_ovf(acc_r, bus.prod, sum_s);
    assign accept_s  = (state_r == ACCUM) && bus.prod_valid && prod_ready_r;
    assign last_s    = ((count_r + LEN_W'(1)) == len_q_r);

    // State register.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_nxt_s = (bus.len != {LEN_W{1'b0}}) ? ACCUM : DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s && last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Accumulator datapath next values; positive overflow yields a negative raw sum.
    always_comb begin
        acc_nxt_s   = acc_r;
        count_nxt_s = count_r;
        len_q_nxt_s = len_q_r;
        ovf_nxt_s   = ovf_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt_s   = {WIDTH{1'b0}};
                    count_nxt_s = {LEN_W{1'b0}};
                    len_q_nxt_s = bus.len;
                    ovf_nxt_s   = 1'b0;
                end else begin
                    acc_nxt_s   = acc_r;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    count_nxt_s = count_r + LEN_W'(1);
                    ovf_nxt_s   = ovf_r | ovf_det_s;
                    if (ovf_det_s && (SATURATE != 0)) begin
                        acc_nxt_s = sum_s[WIDTH-1] ? MAX_POS : MAX_NEG;
                    end else begin
                        acc_nxt_s = sum_s;
                    end
                end else begin
                    acc_nxt_s = acc_r;
                end
            end
            DONE:    acc_nxt_s = acc_r;
            default: acc_nxt_s = acc_r;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            acc_r   <= {WIDTH{1'b0}};
            count_r <= {LEN_W{1'b0}};
            len_q_r <= {LEN_W{1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            acc_r   <= acc_nxt_s;
            count_r <= count_nxt_s;
            len_q_r <= len_q_nxt_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Registered handshake outputs, derived from the state being entered.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            res_r        <= {WIDTH{1'b0}};
            res_valid_r  <= 1'b0;
            prod_ready_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            prod_ready_r <= (state_nxt_s == ACCUM);
            busy_r       <= (state_nxt_s != IDLE);
            res_valid_r  <= (state_nxt_s == DONE);
            if ((state_r != DONE) && (state_nxt_s == DONE)) begin
                res_r <= acc_nxt_s;
            end else begin
                res_r <= res_r;
            end
        end
    end

    assign bus.res        = res_r;
    assign bus.res_valid  = res_valid_r;
    assign bus.prod_ready = prod_ready_r;
    assign bus.busy       = busy_r;
    assign bus.ovf        = ovf_r;

endmodule
